// File: rtl/bus_resp_pkg.sv
// Shared definitions for the timer bus responder: register map, CTRL/STATUS bit
// positions, the ID byte and the bus FSM state encoding.
package bus_resp_pkg;

  localparam logic [2:0] OFF_CTRL      = 3'd0;
  localparam logic [2:0] OFF_STATUS    = 3'd1;
  localparam logic [2:0] OFF_RELOAD_LO = 3'd2;
  localparam logic [2:0] OFF_RELOAD_HI = 3'd3;
  localparam logic [2:0] OFF_COUNT_LO  = 3'd4;
  localparam logic [2:0] OFF_COUNT_HI  = 3'd5;
  localparam logic [2:0] OFF_PRESCALE  = 3'd6;
  localparam logic [2:0] OFF_ID        = 3'd7;

  localparam int CTRL_EN    = 0;
  localparam int CTRL_IE    = 1;
  localparam int CTRL_AUTO  = 2;
  localparam int STATUS_EXP = 0;

  localparam logic [7:0] ID_VALUE = 8'h65;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2
  } bus_state_t;

  // Field order matches the CTRL byte: bit 2 AUTO, bit 1 IE, bit 0 EN.
  typedef struct packed {
    logic auto_rl;
    logic ie;
    logic en;
  } ctrl_t;

  function automatic logic [7:0] ctrl_to_byte(input ctrl_t c);
    return {5'b00000, c.auto_rl, c.ie, c.en};
  endfunction

endpackage

// File: rtl/interval_timer_core.sv
// Interval timer datapath: prescaler, 16-bit down-counter with reload, sticky
// expiry flag and the registered active-low interrupt.
module interval_timer_core
  import bus_resp_pkg::*;
(
  input  logic        clk,
  input  logic        res,
  input  logic        wr_en,
  input  logic [2:0]  wr_off,
  input  logic [7:0]  wr_data,
  output ctrl_t       ctrl,
  output logic        exp_flag,
  output logic [15:0] count,
  output logic [15:0] reload,
  output logic [7:0]  prescale,
  output logic        irq_n
);

  logic [7:0]  psc_q;
  logic [7:0]  psc_d;
  ctrl_t       ctrl_d;
  logic        exp_d;
  logic [15:0] count_d;
  logic [15:0] reload_d;
  logic [7:0]  prescale_d;
  logic        tick;
  logic        expire;

  // Tick and expiry come from the registered CTRL, so a same-cycle CTRL write
  // never changes how the current tick is handled.
  always_comb begin
    tick       = ctrl.en && (psc_q >= prescale);
    expire     = tick && (count == 16'h0000);
    ctrl_d     = ctrl;
    exp_d      = exp_flag;
    count_d    = count;
    reload_d   = reload;
    prescale_d = prescale;
    psc_d      = psc_q;

    if (ctrl.en) psc_d = tick ? 8'h00 : psc_q + 8'h01;

    if (tick) begin
      if (!expire) begin
        count_d = count - 16'h0001;
      end else if (ctrl.auto_rl) begin
        count_d = reload;
      end else begin
        count_d   = 16'h0000;
        ctrl_d.en = 1'b0;
      end
    end

    // Clear first, then set, so an expiry in the same cycle keeps EXP high.
    if (wr_en && (wr_off == OFF_STATUS) && wr_data[STATUS_EXP]) exp_d = 1'b0;
    if (expire) exp_d = 1'b1;

    if (wr_en) begin
      case (wr_off)
        OFF_CTRL:      ctrl_d = ctrl_t'(wr_data[2:0]);
        OFF_RELOAD_LO: reload_d[7:0] = wr_data;
        OFF_RELOAD_HI: begin
          reload_d[15:8] = wr_data;
          count_d        = {wr_data, reload[7:0]};
          psc_d          = 8'h00;
        end
        OFF_PRESCALE:  prescale_d = wr_data;
        default:       ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (res) begin
      ctrl     <= '0;
      exp_flag <= 1'b0;
      count    <= 16'h0000;
      reload   <= 16'h0000;
      prescale <= 8'h00;
      psc_q    <= 8'h00;
      irq_n    <= 1'b1;
    end else begin
      ctrl     <= ctrl_d;
      exp_flag <= exp_d;
      count    <= count_d;
      reload   <= reload_d;
      prescale <= prescale_d;
      psc_q    <= psc_d;
      irq_n    <= ~(exp_d & ctrl_d.ie);
    end
  end

endmodule

// File: rtl/timer_bus_responder.sv
// CPU bus slave for an 8-byte interval timer window with programmable wait states.
// Define TIMER_SNAPSHOT_EN to latch COUNT[15:8] on a COUNT_LO read for coherent 16-bit reads.
//
// state  | meaning
// IDLE   | no access in flight; a selected cycle starts one (or completes it with no wait states)
// WAIT   | RDY held low while the wait-state down-counter runs out
// ACCESS | RDY high, read data driven or write committed, then back to IDLE
module timer_bus_responder
  import bus_resp_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR   = 16'hD000,
  parameter int          WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        res,
  input  logic [15:0] ADDR_BUS,
  input  logic        RW,
  input  logic [7:0]  DATA_IN,
  output logic [7:0]  DATA_OUT,
  output logic        DATA_OE,
  output logic        RDY,
  output logic        IRQ
);

  // The first low cycle is spent in IDLE, so WAIT covers the remaining ones.
  localparam logic [2:0] WAIT_LOAD = 3'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  bus_state_t  state;
  bus_state_t  state_d;
  logic [2:0]  wait_cnt;
  logic [2:0]  wait_d;
  logic [15:0] lat_addr;
  logic        lat_rw;
  logic        latch_req;
  logic        sel;
  logic [2:0]  offset;
  logic        same_req;
  logic        restart;
  logic        complete;
  logic        rdy_c;
  logic        wr_en;
  logic [7:0]  rd_data;
  logic [7:0]  count_hi_rd;

  ctrl_t       ctrl;
  logic        exp_flag;
  logic [15:0] count;
  logic [15:0] reload;
  logic [7:0]  prescale;
  logic        irq_n;

  assign sel      = (ADDR_BUS[15:3] == BASE_ADDR[15:3]);
  assign offset   = ADDR_BUS[2:0];
  assign same_req = (ADDR_BUS == lat_addr) && (RW == lat_rw);
  // A changed request while stalled is treated exactly like a fresh IDLE cycle.
  assign restart  = (state == ST_IDLE) || !same_req;

  always_comb begin
    state_d   = state;
    wait_d    = wait_cnt;
    latch_req = 1'b0;
    complete  = 1'b0;
    rdy_c     = 1'b1;
    if (restart) begin
      state_d = ST_IDLE;
      if (sel) begin
        if (WAIT_STATES == 0) begin
          complete = 1'b1;
        end else begin
          rdy_c     = 1'b0;
          latch_req = 1'b1;
          wait_d    = WAIT_LOAD;
          state_d   = (WAIT_LOAD == 3'd0) ? ST_ACCESS : ST_WAIT;
        end
      end
    end else begin
      case (state)
        ST_WAIT: begin
          rdy_c = 1'b0;
          if (wait_cnt == 3'd1) state_d = ST_ACCESS;
          else                  wait_d  = wait_cnt - 3'd1;
        end
        ST_ACCESS: begin
          complete = 1'b1;
          state_d  = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
    if (res) begin
      complete = 1'b0;
      rdy_c    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (res) begin
      state    <= ST_IDLE;
      wait_cnt <= 3'd0;
      lat_addr <= 16'h0000;
      lat_rw   <= 1'b0;
    end else begin
      state    <= state_d;
      wait_cnt <= wait_d;
      if (latch_req) begin
        lat_addr <= ADDR_BUS;
        lat_rw   <= RW;
      end
    end
  end

`ifdef TIMER_SNAPSHOT_EN
  logic [7:0] snap_hi;

  always_ff @(posedge clk) begin
    if (res)                                               snap_hi <= 8'h00;
    else if (complete && RW && (offset == OFF_COUNT_LO))   snap_hi <= count[15:8];
  end

  assign count_hi_rd = snap_hi;
`else
  assign count_hi_rd = count[15:8];
`endif

  always_comb begin
    rd_data = 8'h00;
    case (offset)
      OFF_CTRL:      rd_data = ctrl_to_byte(ctrl);
      OFF_STATUS:    rd_data = {7'b0000000, exp_flag};
      OFF_RELOAD_LO: rd_data = reload[7:0];
      OFF_RELOAD_HI: rd_data = reload[15:8];
      OFF_COUNT_LO:  rd_data = count[7:0];
      OFF_COUNT_HI:  rd_data = count_hi_rd;
      OFF_PRESCALE:  rd_data = prescale;
      OFF_ID:        rd_data = ID_VALUE;
      default:       rd_data = 8'h00;
    endcase
  end

  assign wr_en    = complete && !RW;
  assign DATA_OE  = complete && RW;
  assign DATA_OUT = DATA_OE ? rd_data : 8'h00;
  assign RDY      = rdy_c;
  assign IRQ      = irq_n;

  interval_timer_core u_core (
    .clk      (clk),
    .res      (res),
    .wr_en    (wr_en),
    .wr_off   (offset),
    .wr_data  (DATA_IN),
    .ctrl     (ctrl),
    .exp_flag (exp_flag),
    .count    (count),
    .reload   (reload),
    .prescale (prescale),
    .irq_n    (irq_n)
  );

endmodule

// File: tb/tb_timer_bus_responder.sv
// Self-checking bench for timer_bus_responder: directed scenarios plus randomized
// bus traffic, all compared every cycle against a behavioural model.
module tb_timer_bus_responder;

  localparam logic [15:0] BASE  = 16'hD000;
  localparam int          TB_WS = 2;
  localparam logic [15:0] IDLE_ADDR = 16'h0000;

  logic        clk = 1'b0;
  logic        res = 1'b1;
  logic [15:0] ADDR_BUS = IDLE_ADDR;
  logic        RW = 1'b1;
  logic [7:0]  DATA_IN = 8'h00;
  logic [7:0]  DATA_OUT;
  logic        DATA_OE;
  logic        RDY;
  logic        IRQ;

  int checks = 0;
  int failures = 0;

  timer_bus_responder #(.BASE_ADDR(BASE), .WAIT_STATES(TB_WS)) dut (
    .clk      (clk),
    .res      (res),
    .ADDR_BUS (ADDR_BUS),
    .RW       (RW),
    .DATA_IN  (DATA_IN),
    .DATA_OUT (DATA_OUT),
    .DATA_OE  (DATA_OE),
    .RDY      (RDY),
    .IRQ      (IRQ)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic        m_en = 0, m_ie = 0, m_auto = 0, m_exp = 0, m_irq = 1;
  logic [15:0] m_count = 0, m_reload = 0;
  logic [7:0]  m_prescale = 0, m_psc = 0, m_snap = 0;
  int          m_age = 0;
  logic [15:0] m_lat_addr = 0;
  logic        m_lat_rw = 0;
  bit          m_init = 0;

  function automatic logic [7:0] m_read(input logic [2:0] off);
    case (off)
      3'd0: return {5'b00000, m_auto, m_ie, m_en};
      3'd1: return {7'b0000000, m_exp};
      3'd2: return m_reload[7:0];
      3'd3: return m_reload[15:8];
      3'd4: return m_count[7:0];
`ifdef TIMER_SNAPSHOT_EN
      3'd5: return m_snap;
`else
      3'd5: return m_count[15:8];
`endif
      3'd6: return m_prescale;
      default: return 8'h65;
    endcase
  endfunction

  task automatic m_clock(input logic wr, input logic [2:0] off, input logic [7:0] d, input logic rd_lo);
    logic tick, expire;
    tick   = m_en && (m_psc >= m_prescale);
    expire = tick && (m_count == 16'h0000);
    if (rd_lo) m_snap = m_count[15:8];
    if (m_en) m_psc = tick ? 8'h00 : m_psc + 8'h01;
    if (tick) begin
      if (!expire)     m_count = m_count - 16'h0001;
      else if (m_auto) m_count = m_reload;
      else             m_en = 1'b0;
    end
    if (wr && off == 3'd1 && d[0]) m_exp = 1'b0;
    if (expire) m_exp = 1'b1;
    if (wr) begin
      case (off)
        3'd0: begin m_en = d[0]; m_ie = d[1]; m_auto = d[2]; end
        3'd2: m_reload[7:0] = d;
        3'd3: begin m_reload[15:8] = d; m_count = {d, m_reload[7:0]}; m_psc = 8'h00; end
        3'd6: m_prescale = d;
        default: ;
      endcase
    end
    m_irq = !(m_exp && m_ie);
  endtask

  task automatic m_reset();
    m_en = 0; m_ie = 0; m_auto = 0; m_exp = 0; m_irq = 1;
    m_count = 0; m_reload = 0; m_prescale = 0; m_psc = 0; m_snap = 0;
    m_age = 0;
  endtask

  // Compare process: an access completes once the same request has been held
  // through TB_WS stalled cycles; any change of request restarts the count.
  always @(negedge clk) begin
    logic sel, cmpl, e_rdy;
    logic [7:0] e_dout;
    sel    = (ADDR_BUS[15:3] == BASE[15:3]);
    cmpl   = 1'b0;
    e_rdy  = 1'b1;
    if (!res) begin
      if (m_age > 0 && (ADDR_BUS != m_lat_addr || RW != m_lat_rw)) m_age = 0;
      if (!sel) begin
        m_age = 0;
      end else if (m_age == TB_WS) begin
        cmpl  = 1'b1;
        m_age = 0;
      end else begin
        e_rdy      = 1'b0;
        m_lat_addr = ADDR_BUS;
        m_lat_rw   = RW;
        m_age      = m_age + 1;
      end
    end
    e_dout = (cmpl && RW) ? m_read(ADDR_BUS[2:0]) : 8'h00;
    check("rdy", RDY, e_rdy);
    check("data_oe", DATA_OE, cmpl && RW);
    check("data_out", DATA_OUT, e_dout);
    if (m_init) check("irq", IRQ, m_irq);
    if (res) begin
      m_reset();
      m_init = 1;
    end else begin
      m_clock(cmpl && !RW, ADDR_BUS[2:0], DATA_IN, cmpl && RW && ADDR_BUS[2:0] == 3'd4);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic access(input logic [15:0] a, input logic rw, input logic [7:0] d,
                        output logic [7:0] rd, output int lows);
    bit done;
    done = 0;
    lows = 0;
    rd   = 8'h00;
    ADDR_BUS = a; RW = rw; DATA_IN = d;
    for (int i = 0; i < 32 && !done; i++) begin
      @(negedge clk);
      if (RDY) begin rd = DATA_OUT; done = 1; end
      else lows++;
      @(posedge clk); #1;
    end
    if (!done) check("access_timeout", 16'd0, 16'd1);
    ADDR_BUS = IDLE_ADDR; RW = 1'b1;
  endtask

  task automatic wr(input logic [2:0] off, input logic [7:0] d);
    logic [7:0] rd; int lows;
    access(BASE + 16'(off), 1'b0, d, rd, lows);
  endtask

  task automatic rd_chk(input string name, input logic [2:0] off, input logic [7:0] exp);
    logic [7:0] rd; int lows;
    access(BASE + 16'(off), 1'b1, 8'h00, rd, lows);
    check(name, rd, exp);
  endtask

  task automatic cycles_to_irq_low(output int n);
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (!IRQ) begin n = i; break; end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    logic [7:0] rd;
    int lows, n;
    logic [2:0] off;
    logic [7:0] d;

    repeat (3) @(posedge clk);
    #1 res = 1'b0;

    @(negedge clk);
    check("reset_irq", IRQ, 1'b1);
    check("reset_rdy", RDY, 1'b1);
    @(posedge clk); #1;

    access(BASE + 16'd7, 1'b1, 8'h00, rd, lows);
    check("id_value", rd, 8'h65);
    check("id_wait_lows", 16'(lows), 16'd2);
    rd_chk("ctrl_after_reset", 3'd0, 8'h00);
    wr(3'd7, 8'hAA);
    rd_chk("id_write_ignored", 3'd7, 8'h65);

    // Auto-reload: expiry on the 4th tick
    wr(3'd2, 8'h03); wr(3'd3, 8'h00); wr(3'd6, 8'h00); wr(3'd0, 8'h07);
    cycles_to_irq_low(n);
    check("auto_ticks_to_exp", 16'(n - 1), 16'd4);
    rd_chk("auto_status", 3'd1, 8'h01);

    // One-shot: EN drops on expiry, COUNT stays 0
    wr(3'd0, 8'h00); wr(3'd1, 8'h01);
    wr(3'd2, 8'h01); wr(3'd3, 8'h00); wr(3'd0, 8'h03);
    cycles_to_irq_low(n);
    check("oneshot_ticks_to_exp", 16'(n - 1), 16'd2);
    rd_chk("oneshot_ctrl", 3'd0, 8'h02);
    rd_chk("oneshot_count_lo", 3'd4, 8'h00);
    rd_chk("oneshot_count_hi", 3'd5, 8'h00);
    rd_chk("oneshot_status", 3'd1, 8'h01);

    // STATUS clear landing on the expiry edge: set wins
    wr(3'd0, 8'h00); wr(3'd1, 8'h01);
    wr(3'd2, 8'h02); wr(3'd3, 8'h00); wr(3'd0, 8'h07);
    wr(3'd1, 8'h01);
    @(negedge clk);
    check("irq_set_wins", IRQ, 1'b0);
    @(posedge clk); #1;
    rd_chk("status_set_wins", 3'd1, 8'h01);
    wr(3'd0, 8'h02); wr(3'd1, 8'h01);
    @(negedge clk);
    check("irq_released", IRQ, 1'b1);
    @(posedge clk); #1;

    // COUNT_LO/COUNT_HI pair around 16'h0100
    wr(3'd2, 8'h02); wr(3'd3, 8'h01); wr(3'd0, 8'h01);
    rd_chk("count_lo_0100", 3'd4, 8'h00);
`ifdef TIMER_SNAPSHOT_EN
    rd_chk("count_hi_snapshot", 3'd5, 8'h01);
`else
    rd_chk("count_hi_live", 3'd5, 8'h00);
`endif
    wr(3'd0, 8'h00);

    // Reset during the WAIT of a CTRL write
    ADDR_BUS = BASE; RW = 1'b0; DATA_IN = 8'h07;
    @(negedge clk);
    check("wr_stall", RDY, 1'b0);
    @(posedge clk); #1 res = 1'b1;
    @(negedge clk);
    check("rdy_in_reset", RDY, 1'b1);
    @(posedge clk); #1 res = 1'b0; ADDR_BUS = IDLE_ADDR; RW = 1'b1;
    @(negedge clk);
    check("rdy_after_reset", RDY, 1'b1);
    @(posedge clk); #1;
    rd_chk("ctrl_after_abort", 3'd0, 8'h00);

    // Randomized traffic with aborts, unselected cycles and rare resets
    for (int c = 0; c < 3000; c++) begin
      res = ($urandom_range(0, 999) == 0);
      if ($urandom_range(0, 99) < 25) begin
        if ($urandom_range(0, 99) < 85) begin
          off = 3'($urandom_range(0, 7));
          d   = 8'($urandom);
          case (off)
            3'd2: d = d & 8'h0F;
            3'd3: d = d & 8'h01;
            3'd6: d = d & 8'h03;
            default: ;
          endcase
          ADDR_BUS = BASE + 16'(off);
          RW       = 1'($urandom);
          DATA_IN  = d;
        end else begin
          ADDR_BUS = {1'b0, 15'($urandom)};
          RW       = 1'($urandom);
          DATA_IN  = 8'($urandom);
        end
      end
      @(posedge clk); #1;
    end
    res = 1'b0;
    ADDR_BUS = IDLE_ADDR; RW = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
